// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus among the execution units,
// feeding a single registered CDB stage consumed through valid/ready.
module cdb_arbiter #(
  parameter int EU_N        = 8,
  parameter int ROB_DEPTH   = 16,
  parameter int XLEN        = 64,
  localparam int ROB_IDX_LEN = $clog2(ROB_DEPTH),
  localparam int SRC_W       = $clog2(EU_N)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic [EU_N-1:0]                     eu_valid_i,
  input  logic [EU_N-1:0][ROB_IDX_LEN-1:0]    eu_rob_idx_i,
  input  logic [EU_N-1:0][XLEN-1:0]           eu_value_i,
  input  logic [EU_N-1:0]                     eu_except_i,
  output logic [EU_N-1:0]                     eu_ready_o,
  output logic                                cdb_valid_o,
  output logic [ROB_IDX_LEN-1:0]              cdb_rob_idx_o,
  output logic [XLEN-1:0]                     cdb_value_o,
  output logic                                cdb_except_o,
  output logic [SRC_W-1:0]                    cdb_src_o,
  input  logic                                cdb_ready_i
);

  logic                   cdb_valid_q,   cdb_valid_d;
  logic [ROB_IDX_LEN-1:0] cdb_rob_idx_q, cdb_rob_idx_d;
  logic [XLEN-1:0]        cdb_value_q,   cdb_value_d;
  logic                   cdb_except_q,  cdb_except_d;
  logic [SRC_W-1:0]       cdb_src_q,     cdb_src_d;
  logic [SRC_W-1:0]       rr_ptr_q,      rr_ptr_d;

  logic             load;
  logic             found;
  logic             grant_en;
  logic [SRC_W-1:0] win;
  int unsigned      k;

  // Grant selection: first valid EU at or after rr_ptr, wrapping.
  always_comb begin
    load  = ~cdb_valid_q | cdb_ready_i;
    found = 1'b0;
    win   = '0;
    k     = 0;
    for (int unsigned i = 0; i < EU_N; i++) begin
      k = (int'(rr_ptr_q) + i) % EU_N;
      if (!found && eu_valid_i[k]) begin
        found = 1'b1;
        win   = SRC_W'(k);
      end
    end
    grant_en   = found & load & ~flush_i & ~rst_i;
    eu_ready_o = grant_en ? (EU_N'(1) << win) : '0;
  end

  always_comb begin
    cdb_valid_d   = cdb_valid_q;
    cdb_rob_idx_d = cdb_rob_idx_q;
    cdb_value_d   = cdb_value_q;
    cdb_except_d  = cdb_except_q;
    cdb_src_d     = cdb_src_q;
    rr_ptr_d      = rr_ptr_q;
    if (flush_i) begin
      // A flushed result is dropped even if the ROB was accepting it.
      cdb_valid_d = 1'b0;
    end else if (grant_en) begin
      cdb_valid_d   = 1'b1;
      cdb_rob_idx_d = eu_rob_idx_i[win];
      cdb_value_d   = eu_value_i[win];
      cdb_except_d  = eu_except_i[win];
      cdb_src_d     = win;
      rr_ptr_d      = (win == SRC_W'(EU_N - 1)) ? '0 : win + SRC_W'(1);
    end else if (load) begin
      cdb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cdb_valid_q   <= 1'b0;
      cdb_rob_idx_q <= '0;
      cdb_value_q   <= '0;
      cdb_except_q  <= 1'b0;
      cdb_src_q     <= '0;
      rr_ptr_q      <= '0;
    end else begin
      cdb_valid_q   <= cdb_valid_d;
      cdb_rob_idx_q <= cdb_rob_idx_d;
      cdb_value_q   <= cdb_value_d;
      cdb_except_q  <= cdb_except_d;
      cdb_src_q     <= cdb_src_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign cdb_valid_o   = cdb_valid_q;
  assign cdb_rob_idx_o = cdb_rob_idx_q;
  assign cdb_value_o   = cdb_value_q;
  assign cdb_except_o  = cdb_except_q;
  assign cdb_src_o     = cdb_src_q;

  a_grant_onehot : assert property (@(posedge clk_i) $onehot0(eu_ready_o));
  a_grant_valid  : assert property (@(posedge clk_i) (eu_ready_o & ~eu_valid_i) == '0);
  a_hold_stable  : assert property (@(posedge clk_i)
    (cdb_valid_q && !cdb_ready_i && !rst_i) |=>
      $stable({cdb_rob_idx_q, cdb_value_q, cdb_except_q, cdb_src_q}));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a reference arbiter model predicts each
// grant and queues the expected CDB result, compared when the CDB holds it.
module tb_cdb_arbiter;

  typedef struct packed {
    logic [3:0]  rob;
    logic [63:0] val;
    logic        exc;
    logic [2:0]  src;
  } res_t;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [7:0]       eu_valid;
  logic [7:0][3:0]  eu_rob;
  logic [7:0][63:0] eu_value;
  logic [7:0]       eu_except;
  logic [7:0]       eu_ready;
  logic             cdb_valid;
  logic [3:0]       cdb_rob;
  logic [63:0]      cdb_value;
  logic             cdb_except;
  logic [2:0]       cdb_src;
  logic             cdb_ready;

  int   n_cmp;
  int   n_err;
  int   m_ptr;
  logic m_valid;
  logic drop_on_grant;
  res_t exp_q[$];

  cdb_arbiter dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .eu_valid_i    (eu_valid),
    .eu_rob_idx_i  (eu_rob),
    .eu_value_i    (eu_value),
    .eu_except_i   (eu_except),
    .eu_ready_o    (eu_ready),
    .cdb_valid_o   (cdb_valid),
    .cdb_rob_idx_o (cdb_rob),
    .cdb_value_o   (cdb_value),
    .cdb_except_o  (cdb_except),
    .cdb_src_o     (cdb_src),
    .cdb_ready_i   (cdb_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of the reference model; inputs are already applied by the caller.
  task automatic tick();
    logic       ld, found, gen;
    int         win;
    logic [7:0] er;
    res_t       r;
    #1;
    ld    = !m_valid || cdb_ready;
    found = 1'b0;
    win   = 0;
    for (int i = 0; i < 8; i++) begin
      int kk;
      kk = (m_ptr + i) % 8;
      if (!found && eu_valid[kk]) begin
        found = 1'b1;
        win   = kk;
      end
    end
    gen = found && ld && !flush && !rst;
    er  = gen ? 8'(1 << win) : 8'h00;
    chk("eu_ready", 64'(eu_ready), 64'(er));
    if (m_valid && exp_q.size() > 0) begin
      r = exp_q[0];
      chk("cdb_rob", 64'(cdb_rob), 64'(r.rob));
      chk("cdb_value", cdb_value, r.val);
      chk("cdb_except", 64'(cdb_except), 64'(r.exc));
      chk("cdb_src", 64'(cdb_src), 64'(r.src));
    end
    if (m_valid && cdb_ready && !flush && !rst) void'(exp_q.pop_front());
    if (rst) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      exp_q.delete();
    end else if (flush) begin
      m_valid = 1'b0;
      exp_q.delete();
    end else if (gen) begin
      r.rob = eu_rob[win];
      r.val = eu_value[win];
      r.exc = eu_except[win];
      r.src = 3'(win);
      exp_q.push_back(r);
      m_valid = 1'b1;
      m_ptr   = (win + 1) % 8;
    end else if (ld) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    chk("rr_ptr", 64'(dut.rr_ptr_q), 64'(m_ptr));
    if (gen) begin
      if (drop_on_grant) eu_valid[win] = 1'b0;
      else begin
        eu_value[win]  = {$urandom, $urandom};
        eu_rob[win]    = 4'($urandom);
        eu_except[win] = 1'($urandom);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; m_ptr = 0; m_valid = 1'b0; drop_on_grant = 1'b1;
    rst = 1'b1; flush = 1'b0; cdb_ready = 1'b0;
    eu_valid = '0; eu_except = '0;
    for (int i = 0; i < 8; i++) begin
      eu_rob[i]   = 4'(i);
      eu_value[i] = 64'(i) * 64'h0101_0101_0101_0101;
    end
    @(posedge clk);
    #1;

    // Reset then idle
    tick();
    tick();
    chk("rst_rob", 64'(cdb_rob), 64'h0);
    chk("rst_value", cdb_value, 64'h0);
    chk("rst_except", 64'(cdb_except), 64'h0);
    chk("rst_src", 64'(cdb_src), 64'h0);
    rst = 1'b0;
    tick();

    // Single requester: EU3
    cdb_ready   = 1'b1;
    eu_valid[3] = 1'b1;
    eu_rob[3]   = 4'd5;
    eu_value[3] = 64'hDEAD_BEEF;
    eu_except[3] = 1'b1;
    tick();
    tick();
    tick();

    // Round robin with all EUs requesting from pointer 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drop_on_grant = 1'b0;
    eu_valid = 8'hFF;
    repeat (10) tick();
    eu_valid = '0;
    drop_on_grant = 1'b1;
    tick();

    // Backpressure: EU2 held on the CDB while EU5 waits
    rst = 1'b1;
    tick();
    rst = 1'b0;
    eu_valid[2] = 1'b1;
    eu_value[2] = 64'h2222_0000_1111_AAAA;
    tick();
    cdb_ready   = 1'b0;
    eu_valid[5] = 1'b1;
    eu_value[5] = 64'h5555_CAFE_F00D_0005;
    repeat (3) tick();
    cdb_ready = 1'b1;
    tick();
    tick();
    tick();

    // Flush with EU1 on the CDB and EU4 pending
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cdb_ready   = 1'b0;
    eu_valid[1] = 1'b1;
    tick();
    eu_valid[4] = 1'b1;
    eu_value[4] = 64'h4444_4444_ABCD_0004;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cdb_ready = 1'b1;
    tick();
    tick();

    // Reset in the middle of a held result
    cdb_ready   = 1'b0;
    eu_valid[6] = 1'b1;
    tick();
    eu_valid[1] = 1'b1;
    eu_valid[3] = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cdb_ready = 1'b1;
    tick();
    tick();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
